ieeedrv_trkload: RTL and testbench

IEEEDRV_TRKLOAD -- requirements
Module: ieeedrv_trkload

---
 rtl/ieeedrv_trkload.sv | 221 ++++++++++++++++++++++
 tb/tb_ieeedrv_trkload.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieeedrv_trkload.sv
// ieeedrv_trkload: moves one track between the SD card and the shared track
// buffer, one 512-byte block at a time.
// A new track is loaded when the selected sub-drive or the requested track
// differs from the buffered one. Optional write-back of a modified buffer is
// compiled in with the macro IEEEDRV_TRKLOAD_WRITEBACK_EN. Without it the
// buffer is read-only and sd_wr is tied low.
// sd_rd/sd_wr are level requests. A request is held with a stable sd_lba and
// buf_page until sd_ack rises. A block counts as complete when sd_ack falls.
module ieeedrv_trkload #(
    parameter  int SUBDRV = 2,
    localparam int DRV_W  = (SUBDRV > 1) ? $clog2(SUBDRV) : 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              loaded,
    input  logic [DRV_W-1:0]  drv_act,
    input  logic [7:0]        track,
    input  logic [31:0]       trk_lba,
    input  logic [4:0]        trk_sectors,
    input  logic              we,
    output logic              busy,
    output logic [31:0]       sd_lba,
    output logic              sd_rd,
    output logic              sd_wr,
    input  logic              sd_ack,
    output logic [3:0]        buf_page,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
        ST_WB_REQ  = 3'd1,
        ST_WB_WAIT = 3'd2,
`endif
        ST_RD_REQ  = 3'd3,
        ST_RD_WAIT = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         blk_q, blk_d;
    logic               valid_q, valid_d;
    logic [7:0]         cur_track_q, cur_track_d;
    logic [DRV_W-1:0]   cur_drv_q, cur_drv_d;
    logic [31:0]        cur_lba_q, cur_lba_d;
    logic [3:0]         cur_blocks_q, cur_blocks_d;
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
    logic               dirty_q, dirty_d;
`endif

    logic start_c;      // buffer does not hold the requested track
    logic wb_needed;    // buffer content must go back to the card first
    logic load_new;     // latch requested track and begin the read phase
    logic abort;        // disk unmounted: drop everything, no write-back
    logic unused_ok;

    // Sector 0 only matters for rounding up, which trk_sectors[4:1] already does.
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
    assign unused_ok = trk_sectors[0];
`else
    assign unused_ok = trk_sectors[0] ^ we;
`endif

    assign start_c = (track != 8'hFF) &&
                     ((track != cur_track_q) || (drv_act != cur_drv_q) || !valid_q);

    // A write in the same cycle as the start still counts as a modification.
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
    assign wb_needed = dirty_q | (we & valid_q);
`else
    assign wb_needed = 1'b0;
`endif

    // State and datapath registers; reset withdraws any request at once.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            blk_q        <= 4'd0;
            valid_q      <= 1'b0;
            cur_track_q  <= 8'hFF;
            cur_drv_q    <= '0;
            cur_lba_q    <= 32'd0;
            cur_blocks_q <= 4'd0;
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
            dirty_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            valid_q      <= valid_d;
            cur_track_q  <= cur_track_d;
            cur_drv_q    <= cur_drv_d;
            cur_lba_q    <= cur_lba_d;
            cur_blocks_q <= cur_blocks_d;
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
            dirty_q      <= dirty_d;
`endif
        end
    end

    // Next-state and datapath update: sequence the blocks of each phase.
    always_comb begin
        state_d      = state_q;
        blk_d        = blk_q;
        valid_d      = valid_q;
        cur_track_d  = cur_track_q;
        cur_drv_d    = cur_drv_q;
        cur_lba_d    = cur_lba_q;
        cur_blocks_d = cur_blocks_q;
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
        dirty_d      = dirty_q;
`endif
        load_new     = 1'b0;
        abort        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!loaded) begin
                    abort = 1'b1;
                end else begin
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
                    dirty_d = wb_needed;
`endif
                    if (start_c) begin
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
                        if (wb_needed) begin
                            blk_d   = 4'd0;
                            state_d = ST_WB_REQ;
                        end else
`endif
                        begin
                            load_new = 1'b1;
                            state_d  = ST_RD_REQ;
                        end
                    end
                end
            end
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
            ST_WB_REQ: begin
                if (sd_ack)       state_d = ST_WB_WAIT;
                else if (!loaded) abort   = 1'b1;
            end
            ST_WB_WAIT: begin
                if (!sd_ack) begin
                    if (!loaded) begin
                        abort = 1'b1;
                    end else if (blk_q == cur_blocks_q) begin
                        dirty_d = 1'b0;
                        if (track != 8'hFF) begin
                            load_new = 1'b1;
                            state_d  = ST_RD_REQ;
                        end else begin
                            blk_d   = 4'd0;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        state_d = ST_WB_REQ;
                    end
                end
            end
`endif
            ST_RD_REQ: begin
                if (sd_ack)       state_d = ST_RD_WAIT;
                else if (!loaded) abort   = 1'b1;
            end
            ST_RD_WAIT: begin
                if (!sd_ack) begin
                    if (!loaded) begin
                        abort = 1'b1;
                    end else if (blk_q == cur_blocks_q) begin
                        valid_d = 1'b1;
                        blk_d   = 4'd0;
                        state_d = ST_IDLE;
                    end else begin
                        blk_d   = blk_q + 4'd1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                blk_d   = 4'd0;
            end
        endcase

        // The buffer is invalid from the first overwritten byte until the last block lands.
        if (load_new) begin
            cur_track_d  = track;
            cur_drv_d    = drv_act;
            cur_lba_d    = trk_lba;
            cur_blocks_d = trk_sectors[4:1];
            valid_d      = 1'b0;
            blk_d        = 4'd0;
        end

        if (abort) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            blk_d   = 4'd0;
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
            dirty_d = 1'b0;
`endif
        end
    end

    // Outputs decoded from the registered state, so they drop on the same edge as reset.
    always_comb begin
        busy        = (state_q != ST_IDLE);
        sd_rd       = (state_q == ST_RD_REQ);
`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
        sd_wr       = (state_q == ST_WB_REQ);
`else
        sd_wr       = 1'b0;
`endif
        sd_lba      = busy ? (cur_lba_q + {28'd0, blk_q}) : 32'd0;
        buf_page    = blk_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_ieeedrv_trkload.sv
// Testbench for ieeedrv_trkload: a responder plays the SD host. A reference
// model of which blocks each track request must move feeds an expected
// queue. A monitor compares every acknowledged request against that queue.
module tb_ieeedrv_trkload;

`ifdef IEEEDRV_TRKLOAD_WRITEBACK_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        loaded;
    logic [0:0]  drv_act;
    logic [7:0]  track;
    logic [31:0] trk_lba;
    logic [4:0]  trk_sectors;
    logic        we;
    logic        busy;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;
    logic [3:0]  buf_page;
    logic [2:0]  dbg_state;

    ieeedrv_trkload #(.SUBDRV(2)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .loaded      (loaded),
        .drv_act     (drv_act),
        .track       (track),
        .trk_lba     (trk_lba),
        .trk_sectors (trk_sectors),
        .we          (we),
        .busy        (busy),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .buf_page    (buf_page),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk_sys = ~clk_sys;

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [36:0] exp_q[$];          // {is_write, lba, page}
    int          ack_count   = 0;
    int          wr_seen     = 0;
    int          wr_expected = 0;
    bit          host_hold   = 1'b0;

    // ---------------- reference model ----------------
    bit          m_valid;
    bit          m_dirty;
    logic [7:0]  m_track;
    logic [0:0]  m_drv;
    logic [31:0] m_lba;
    logic [4:0]  m_sec;

    function automatic logic [31:0] lba_of(input int drv, input int trk);
        if (drv == 0 && trk == 1) return 32'd100;
        if (drv == 0 && trk == 2) return 32'd111;
        return 32'(300 + trk * 50 + drv * 700);
    endfunction

    function automatic logic [4:0] sec_of(input int drv, input int trk);
        int s;
        if (drv == 0 && (trk == 1 || trk == 2)) return 5'd20;
        s = (trk * 7 + drv * 13) % 32;
        return s[4:0];
    endfunction

    // A track of (sectors+1) 256-byte sectors occupies ceil((sectors+1)/2) SD blocks.
    function automatic void push_phase(input bit wr, input logic [31:0] lba, input logic [4:0] sectors);
        int nblk;
        nblk = (int'(sectors) + 2) / 2;
        for (int i = 0; i < nblk; i++) begin
            exp_q.push_back({wr, lba + 32'(i), i[3:0]});
            if (wr) wr_expected++;
        end
    endfunction

    // Returns 1 when the current inputs make the drive fetch a new track.
    function automatic bit model_eval();
        if (!loaded || track == 8'hFF) return 1'b0;
        if (m_valid && track == m_track && drv_act == m_drv) return 1'b0;
        if (m_dirty) push_phase(1'b1, m_lba, m_sec);
        m_dirty = 1'b0;
        push_phase(1'b0, trk_lba, trk_sectors);
        m_track = track;
        m_drv   = drv_act;
        m_lba   = trk_lba;
        m_sec   = trk_sectors;
        m_valid = 1'b1;
        return 1'b1;
    endfunction

    function automatic void model_we(input bit idle);
        if (WB_EN && idle && loaded && m_valid) m_dirty = 1'b1;
    endfunction

    function automatic void flush_q();
        foreach (exp_q[i]) if (exp_q[i][36]) wr_expected--;
        exp_q.delete();
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic set_track(input int drv, input int trk, output bit started);
        drv_act     = 1'(drv);
        track       = (trk == 255) ? 8'hFF : 8'(trk);
        trk_lba     = lba_of(drv, trk);
        trk_sectors = sec_of(drv, trk);
        started     = model_eval();
    endtask

    task automatic pulse_we(input bit idle);
        we = 1'b1;
        model_we(idle);
        tick();
        we = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int quiet;
        int i;
        quiet = 0;
        i = 0;
        while (quiet < 3 && i < budget) begin
            tick();
            i++;
            if (!busy) quiet++;
            else quiet = 0;
        end
        check("idle_within_budget", 64'(quiet >= 3), 64'd1);
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int i;
        i = 0;
        while (ack_count < n && i < budget) begin
            tick();
            i++;
        end
        check("acks_within_budget", 64'(ack_count >= n), 64'd1);
    endtask

    // ---------------- SD host responder ----------------
    initial begin
        int d;
        int h;
        sd_ack = 1'b0;
        forever begin
            tick();
            if (!reset && !host_hold && (sd_rd || sd_wr) && !sd_ack) begin
                d = $urandom_range(0, 3);
                repeat (d) tick();
                if (!reset && !host_hold && (sd_rd || sd_wr)) begin
                    sd_ack = 1'b1;
                    h = $urandom_range(1, 3);
                    repeat (h) tick();
                    sd_ack = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic        ack_prev;
        logic [36:0] e;
        ack_prev = 1'b0;
        forever begin
            @(negedge clk_sys);
            if (!reset) begin
                check("rd_wr_exclusive", 64'(sd_rd & sd_wr), 64'd0);
                if (sd_ack && !ack_prev && (sd_rd || sd_wr)) begin
                    ack_count++;
                    if (sd_wr) wr_seen++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_request", {27'd0, sd_wr, sd_lba, buf_page}, 64'h1_FFFF_FFFF_F);
                    end else begin
                        e = exp_q.pop_front();
                        check("req_op_lba_page", {27'd0, sd_wr, sd_lba, buf_page}, {27'd0, e});
                    end
                end
                if (sd_ack && ack_prev) check("req_dropped_after_ack", 64'(sd_rd | sd_wr), 64'd0);
            end
            ack_prev = sd_ack;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit st;
        int base;
        int i;
        reset = 1'b1; loaded = 1'b0; drv_act = 1'b0; track = 8'hFF;
        trk_lba = 32'd0; trk_sectors = 5'd0; we = 1'b0;
        m_valid = 1'b0; m_dirty = 1'b0; m_track = 8'hFF; m_drv = 1'b0;
        m_lba = 32'd0; m_sec = 5'd0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sd_rd", 64'(sd_rd), 64'd0);
        check("rst_sd_wr", 64'(sd_wr), 64'd0);
        check("rst_sd_lba", 64'(sd_lba), 64'd0);
        check("rst_buf_page", 64'(buf_page), 64'd0);
        reset = 1'b0;
        tick();

        // First load: track 1, 11 blocks from LBA 100.
        base = ack_count;
        loaded = 1'b1;
        set_track(0, 1, st);
        tick();
        check("busy_after_start", 64'(busy), 64'(st));
        wait_idle(2000);
        check("first_load_reads", 64'(ack_count - base), 64'd11);

        // Modify the buffer, park on "no track", then request track 2.
        pulse_we(1'b1);
        set_track(0, 255, st);
        tick();
        check("no_track_stays_idle", 64'(busy), 64'(st));
        repeat (5) tick();
        check("no_track_still_idle", 64'(busy), 64'd0);
        base = ack_count;
        set_track(0, 2, st);
        tick();
        check("busy_after_start", 64'(busy), 64'(st));
        wait_idle(3000);
        check("wb_then_read_count", 64'(ack_count - base), WB_EN ? 64'd22 : 64'd11);

        // Track change while the third read block is in flight; a write strobe meanwhile is ignored.
        set_track(0, 4, st);
        base = ack_count;
        wait_acks(base + 3, 500);
        pulse_we(1'b0);
        set_track(1, 1, st);
        wait_idle(3000);

        // Randomized requests, sometimes after modifying the buffer.
        for (i = 0; i < 10; i++) begin
            int drv;
            int trk;
            if ($urandom_range(0, 2) == 0) pulse_we(1'b1);
            drv = $urandom_range(0, 1);
            trk = $urandom_range(0, 5);
            if (trk == 5) trk = 255;
            set_track(drv, trk, st);
            tick();
            check("busy_after_request", 64'(busy), 64'(st));
            wait_idle(3000);
        end

        // Unmount while the first request is pending and not acknowledged.
        set_track(0, 6, st);
        tick();
        wait_idle(3000);
        host_hold = 1'b1;
        pulse_we(1'b1);
        set_track(0, 3, st);
        tick();
        check("pending_is_write", 64'(sd_wr), 64'(WB_EN));
        check("pending_is_read", 64'(sd_rd), 64'(!WB_EN));
        loaded = 1'b0;
        tick();
        check("unload_sd_wr", 64'(sd_wr), 64'd0);
        check("unload_sd_rd", 64'(sd_rd), 64'd0);
        check("unload_busy", 64'(busy), 64'd0);
        flush_q();
        m_valid = 1'b0;
        m_dirty = 1'b0;
        repeat (3) tick();
        host_hold = 1'b0;
        loaded = 1'b1;
        st = model_eval();
        tick();
        check("reload_after_mount", 64'(busy), 64'(st));
        wait_idle(3000);

        // Reset while waiting for the end of a read block.
        set_track(1, 2, st);
        base = ack_count;
        wait_acks(base + 3, 500);
        i = 0;
        while (!(sd_ack && busy && !sd_rd && !sd_wr) && i < 200) begin
            tick();
            i++;
        end
        check("reached_rd_wait", 64'(i < 200), 64'd1);
        reset = 1'b1;
        tick();
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_sd_rd", 64'(sd_rd), 64'd0);
        check("midrst_sd_wr", 64'(sd_wr), 64'd0);
        check("midrst_sd_lba", 64'(sd_lba), 64'd0);
        check("midrst_buf_page", 64'(buf_page), 64'd0);
        flush_q();
        m_valid = 1'b0; m_dirty = 1'b0; m_track = 8'hFF; m_drv = 1'b0;
        repeat (5) tick();
        st = model_eval();
        reset = 1'b0;
        tick();
        check("reload_after_reset", 64'(busy), 64'(st));
        wait_idle(3000);

        check("write_requests_total", 64'(wr_seen), 64'(wr_expected));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
